// File: rtl/b2b_router_pkg.sv
// b2b_router_pkg: marker constants, FSM states and header/footer decode for the event router
package b2b_router_pkg;

    localparam logic [7:0] HDR_MARK = 8'hAB;
    localparam logic [7:0] FTR_MARK = 8'hCD;
    localparam int MARK_HI = 63;
    localparam int MARK_LO = 56;

    typedef enum logic {IDLE, FORWARD} state_t;

    function automatic logic is_header(input logic flag, input logic [7:0] mark);
        return flag && (mark == HDR_MARK);
    endfunction

    function automatic logic is_footer(input logic flag, input logic [7:0] mark);
        return flag && (mark == FTR_MARK);
    endfunction

endpackage

// File: rtl/b2b_rr_arbiter.sv
// b2b_rr_arbiter: rotating-priority grant starting after the last winner, updated on advance
module b2b_rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic          valid,
    output logic [IW-1:0] grant
);

    logic [IW-1:0] last;

    // scan downward so the closest requester after last wins
    always_comb begin
        valid = |req;
        grant = '0;
        for (int k = N; k >= 1; k--)
            if (req[(int'(last) + k) % N]) grant = IW'((int'(last) + k) % N);
    end

    // remember the winner only when the grant is actually taken
    always_ff @(posedge clock) begin
        if (reset) last <= IW'(N - 1);
        else if (advance) last <= grant;
    end

endmodule

// File: rtl/b2b_event_router.sv
// b2b_event_router: whole-event round-robin multicast router; B2B_ROUTER_STATS_EN builds the counters
module b2b_event_router
    import b2b_router_pkg::*;
#(
    parameter int DATA_WIDTH = 65,
    parameter int N_INPUTS   = 4,
    parameter int N_OUTPUTS  = 14
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [N_INPUTS-1:0][DATA_WIDTH-1:0]   in_data,
    input  logic [N_INPUTS-1:0]                   in_empty,
    output logic [N_INPUTS-1:0]                   in_rd_en,
    output logic [N_OUTPUTS-1:0][DATA_WIDTH-1:0]  out_data,
    output logic [N_OUTPUTS-1:0]                  out_wren,
    input  logic [N_OUTPUTS-1:0]                  out_almost_full,
    output logic                                  busy,
    output logic [31:0]                           drop_count,
    output logic [N_OUTPUTS-1:0][31:0]            out_event_count
);

    localparam int IW = $clog2(N_INPUTS);

    state_t state, state_n;
    logic [IW-1:0] sel, sel_n, arb_grant, jsel;
    logic [N_OUTPUTS-1:0] mask, mask_n, wr_mask, cand_mask;
    logic [N_INPUTS-1:0] hdr, junk, rd;
    logic [DATA_WIDTH-1:0] word;
    logic gap, arb_valid, advance, foot;

    b2b_rr_arbiter #(.N(N_INPUTS)) u_arb (
        .clock(clock),
        .reset(reset),
        .req(hdr),
        .advance(advance),
        .valid(arb_valid),
        .grant(arb_grant)
    );

    // classify each FIFO head and find the lowest non-header head to discard
    always_comb begin
        jsel = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            hdr[i]  = ~in_empty[i] & is_header(in_data[i][DATA_WIDTH-1], in_data[i][MARK_HI:MARK_LO]);
            junk[i] = ~in_empty[i] & ~hdr[i];
        end
        for (int i = N_INPUTS - 1; i >= 0; i--)
            if (junk[i]) jsel = IW'(i);
    end

    // pop/route decision: header grant or drop in IDLE, gated word transfer in FORWARD
    always_comb begin
        state_n   = state;
        sel_n     = sel;
        mask_n    = mask;
        rd        = '0;
        wr_mask   = '0;
        advance   = 1'b0;
        cand_mask = in_data[arb_grant][N_OUTPUTS-1:0];
        word      = (state == IDLE && arb_valid) ? in_data[arb_grant] : in_data[sel];
        foot      = is_footer(word[DATA_WIDTH-1], word[MARK_HI:MARK_LO]);
        if (state == IDLE) begin
            if (!gap && arb_valid) begin
                if ((cand_mask & out_almost_full) == '0) begin
                    rd[arb_grant] = 1'b1;
                    wr_mask       = cand_mask;
                    advance       = 1'b1;
                    sel_n         = arb_grant;
                    mask_n        = cand_mask;
                    state_n       = FORWARD;
                end
            end else if (!gap && |junk) begin
                rd[jsel] = 1'b1;
            end
        end else if (!in_empty[sel] && (mask & out_almost_full) == '0) begin
            rd[sel] = 1'b1;
            wr_mask = mask;
            if (foot) state_n = IDLE;
        end
    end

    assign in_rd_en = reset ? '0 : rd;
    assign busy     = (state == FORWARD);

    // state, latched event context and the registered write port
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= '0;
            mask     <= '0;
            gap      <= 1'b0;
            out_wren <= '0;
            out_data <= '0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            mask     <= mask_n;
            gap      <= (state == FORWARD) && (state_n == IDLE);
            out_wren <= wr_mask;
            for (int j = 0; j < N_OUTPUTS; j++)
                if (wr_mask[j]) out_data[j] <= word;
        end
    end

`ifdef B2B_ROUTER_STATS_EN
    logic drop;

    assign drop = (state == IDLE) && |rd && !advance;

    // saturating drop and per-output delivered-event counters
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count      <= '0;
            out_event_count <= '0;
        end else begin
            if (drop && drop_count != '1) drop_count <= drop_count + 32'd1;
            for (int j = 0; j < N_OUTPUTS; j++)
                if (wr_mask[j] && foot && out_event_count[j] != '1)
                    out_event_count[j] <= out_event_count[j] + 32'd1;
        end
    end
`else
    assign drop_count      = '0;
    assign out_event_count = '0;
`endif

endmodule
